dmem_cache_model: RTL and testbench

- Parametrised verification data-memory model for the Ibex LSU data port. It emulates a single-line tag cache with a configurable miss penalty.
- It keeps a circular log of the last ENTRIES written bytes. Loads return the newest logged byte per lane, or a deterministic address-derived pattern when no byte is logged.
- It exposes the log and access statistics so the contract checker can observe memory state.
- It sits between the core data interface and the bench/formal harness.

---
 rtl/dmem_cache_model.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_cache_model.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_cache_model.sv
// Data-memory model for the Ibex LSU port: single-line tag cache with miss penalty,
// circular byte write log, address-derived read pattern and an error region.
module dmem_cache_model #(
  parameter int unsigned ENTRIES      = 32,
  parameter int unsigned LINE_BYTES   = 4,
  parameter int unsigned MISS_LATENCY = 2,
  parameter logic [31:0] PATTERN_MOD  = 32'h1000,
  parameter logic [31:0] ERR_BASE     = 32'hFFFF_F000,
  parameter logic [31:0] ERR_SIZE     = 32'h1000
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       data_req_i,
  input  logic                       data_we_i,
  input  logic [3:0]                 data_be_i,
  input  logic [31:0]                data_addr_i,
  input  logic [31:0]                data_wdata_i,
  output logic                       data_gnt_o,
  output logic                       data_rvalid_o,
  output logic [31:0]                data_rdata_o,
  output logic                       data_err_o,
  output logic [ENTRIES*32-1:0]      log_addr_o,
  output logic [ENTRIES*8-1:0]       log_data_o,
  output logic [ENTRIES-1:0]         log_valid_o,
  output logic [$clog2(ENTRIES)-1:0] log_wptr_o,
  output logic [31:0]                miss_count_o
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);
  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned TAG_W = 32 - OFF_W;
  localparam int unsigned CNT_W = $clog2(MISS_LATENCY + 1);

  typedef enum logic {
    ST_IDLE,
    ST_MISS
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic               r_tagValid;
  logic [TAG_W-1:0]   r_tag;
  logic [31:0]        r_missCount;
  logic               w_gnt;
  logic               w_missInc;

  logic [31:0]        r_logAddr [ENTRIES];
  logic [7:0]         r_logData [ENTRIES];
  logic [ENTRIES-1:0] r_logValid;
  logic [PTR_W-1:0]   r_wptr;

  logic               r_rvalid;
  logic [31:0]        r_rdata;
  logic               r_err;

  logic [31:0]        w_wordAddr;
  logic [TAG_W-1:0]   w_line;
  logic               w_hit;
  logic [32:0]        w_errEnd;
  logic               w_errHit;
  logic [31:0]        w_loadData;
  logic [1:0]         w_laneOff [4];
  logic [PTR_W-1:0]   w_pushIdx [4];
  logic [2:0]         w_pushCnt;
  logic               w_doPush;
  logic               w_unused;

  assign w_wordAddr = {data_addr_i[31:2], 2'b00};
  assign w_line     = data_addr_i[31:OFF_W];
  assign w_hit      = r_tagValid && (w_line == r_tag);
  assign w_unused   = ^data_addr_i[1:0];

  // 33-bit end address so a region touching the top of memory does not wrap.
  assign w_errEnd = {1'b0, ERR_BASE} + {1'b0, ERR_SIZE};
  assign w_errHit = (ERR_SIZE != 32'd0) &&
                    ({1'b0, w_wordAddr} >= {1'b0, ERR_BASE}) &&
                    ({1'b0, w_wordAddr} < w_errEnd);

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_gnt       = 1'b0;
    w_missInc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (data_req_i) begin
          if (w_hit) begin
            w_gnt = 1'b1;
          end else begin
            w_missInc   = 1'b1;
            w_cntNext   = CNT_W'(MISS_LATENCY);
            w_stateNext = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        if (!data_req_i) begin
          w_stateNext = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_gnt       = 1'b1;
          w_stateNext = ST_IDLE;
        end else begin
          w_cntNext = r_cnt - 1'b1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_tagValid  <= 1'b0;
      r_tag       <= '0;
      r_missCount <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      if (w_gnt) begin
        r_tagValid <= 1'b1;
        r_tag      <= w_line;
      end
      if (w_missInc && (r_missCount != 32'hFFFF_FFFF)) begin
        r_missCount <= r_missCount + 32'd1;
      end
    end
  end

  // Walk the log oldest-to-newest (starting at wptr) so the newest match overwrites.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    w_loadData = w_wordAddr % PATTERN_MOD;
    for (int i = 0; i < ENTRIES; i++) begin
      idx = r_wptr + PTR_W'(i);
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k] && r_logValid[idx] &&
            (r_logAddr[idx] == {w_wordAddr[31:2], 2'(k)})) begin
          w_loadData[8*k +: 8] = r_logData[idx];
        end
      end
    end
  end

  always_comb begin
    logic [2:0] acc;
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      w_laneOff[k] = acc[1:0];
      w_pushIdx[k] = r_wptr + PTR_W'(acc[1:0]);
      acc          = acc + {2'b00, data_be_i[k]};
    end
    w_pushCnt = acc;
  end

  assign w_doPush = w_gnt && data_we_i && !w_errHit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_logAddr[i] <= '0;
        r_logData[i] <= '0;
      end
      r_logValid <= '0;
      r_wptr     <= '0;
    end else if (w_doPush) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) begin
          r_logAddr[w_pushIdx[k]]  <= {w_wordAddr[31:2], 2'(k)};
          r_logData[w_pushIdx[k]]  <= data_wdata_i[8*k +: 8];
          r_logValid[w_pushIdx[k]] <= 1'b1;
        end
      end
      r_wptr <= r_wptr + PTR_W'(w_pushCnt);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt) begin
        r_err   <= w_errHit;
        r_rdata <= (w_errHit || data_we_i) ? 32'd0 : w_loadData;
      end
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_logFlat
    assign log_addr_o[32*i +: 32] = r_logAddr[i];
    assign log_data_o[8*i +: 8]   = r_logData[i];
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_rdata;
  assign data_err_o    = r_err;
  assign log_valid_o   = r_logValid;
  assign log_wptr_o    = r_wptr;
  assign miss_count_o  = r_missCount;

endmodule

// File: tb/tb_dmem_cache_model.sv
// Directed bench for dmem_cache_model: miss timing, store logging, log wrap,
// newest-wins merge, error region, back-to-back grants and reset during a miss.
module tb_dmem_cache_model;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          data_req_i;
  logic          data_we_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i;
  logic [31:0]   data_wdata_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [31:0]   data_rdata_o;
  logic          data_err_o;
  logic [32*32-1:0] log_addr_o;
  logic [32*8-1:0]  log_data_o;
  logic [31:0]   log_valid_o;
  logic [4:0]    log_wptr_o;
  logic [31:0]   miss_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dmem_cache_model dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_req_i   (data_req_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_gnt_o   (data_gnt_o),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .log_addr_o   (log_addr_o),
    .log_data_o   (log_data_o),
    .log_valid_o  (log_valid_o),
    .log_wptr_o   (log_wptr_o),
    .miss_count_o (miss_count_o)
  );

  task automatic do_reset();
    rst_ni       = 1'b0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // One transaction; returns cycles waited before grant (-1 on timeout) and the response.
  task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output int waitCycles,
                        output logic rv, output logic [31:0] rd, output logic er);
    logic granted;
    granted      = 1'b0;
    waitCycles   = -1;
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk_i);
      if (data_gnt_o) begin
        waitCycles = c;
        granted    = 1'b1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    @(posedge clk_i);
    #1;
    rv = data_rvalid_o;
    rd = data_rdata_o;
    er = data_err_o;
    if (!granted) begin
      rv = 1'b0;
      $display("[TB] timeout waiting for grant at addr %h", addr);
    end
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    data_be_i  = 4'h0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_ni = 1'b0;
    #1;
    checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 0", data_gnt_o); end
    checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 0", data_rvalid_o); end
    checks++; if (data_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", data_rdata_o); end
    checks++; if (log_valid_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_valid: got %h want 0", log_valid_o); end
    checks++; if (log_wptr_o !== 5'd0) begin errors++; $display("[TB] FAIL reset_wptr: got %0d want 0", log_wptr_o); end
    checks++; if (miss_count_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_miss: got %0d want 0", miss_count_o); end
    do_reset();
  endtask

  task automatic test_miss_load();
    int w; logic rv; logic [31:0] rd; logic er;
    access(1'b0, 4'hF, 32'h0000_0104, 32'h0, w, rv, rd, er);
    checks++; if (w !== 3) begin errors++; $display("[TB] FAIL miss_wait: got %0d want 3", w); end
    checks++; if (rv !== 1'b1) begin errors++; $display("[TB] FAIL miss_rvalid: got %b want 1", rv); end
    checks++; if (rd !== 32'h0000_0104) begin errors++; $display("[TB] FAIL miss_rdata: got %h want 00000104", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL miss_err: got %b want 0", er); end
    checks++; if (miss_count_o !== 32'd1) begin errors++; $display("[TB] FAIL miss_count: got %0d want 1", miss_count_o); end
  endtask

  task automatic test_store_hit();
    int w; logic rv; logic [31:0] rd; logic er;
    access(1'b1, 4'b0101, 32'h0000_0104, 32'hAABB_CCDD, w, rv, rd, er);
    checks++; if (w !== 0) begin errors++; $display("[TB] FAIL store_wait: got %0d want 0", w); end
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL store_rdata: got %h want 0", rd); end
    access(1'b0, 4'hF, 32'h0000_0104, 32'h0, w, rv, rd, er);
    checks++; if (rd !== 32'h00BB_01DD) begin errors++; $display("[TB] FAIL merge_rdata: got %h want 00bb01dd", rd); end
    checks++; if (log_addr_o[31:0] !== 32'h104 || log_data_o[7:0] !== 8'hDD) begin errors++; $display("[TB] FAIL slot0: got %h/%h want 104/dd", log_addr_o[31:0], log_data_o[7:0]); end
    checks++; if (log_addr_o[63:32] !== 32'h106 || log_data_o[15:8] !== 8'hBB) begin errors++; $display("[TB] FAIL slot1: got %h/%h want 106/bb", log_addr_o[63:32], log_data_o[15:8]); end
    checks++; if (log_wptr_o !== 5'd2) begin errors++; $display("[TB] FAIL store_wptr: got %0d want 2", log_wptr_o); end
    checks++; if (log_valid_o !== 32'h3) begin errors++; $display("[TB] FAIL store_valid: got %h want 3", log_valid_o); end
  endtask

  task automatic test_wrap();
    int w; logic rv; logic [31:0] rd; logic er;
    int lane;
    do_reset();
    for (int n = 0; n < 36; n++) begin
      lane = n % 4;
      access(1'b1, 4'(1 << lane), 32'h200 + 32'(n), 32'(8'h40 + n) << (8 * lane), w, rv, rd, er);
    end
    checks++; if (miss_count_o !== 32'd9) begin errors++; $display("[TB] FAIL wrap_miss: got %0d want 9", miss_count_o); end
    checks++; if (log_wptr_o !== 5'd4) begin errors++; $display("[TB] FAIL wrap_wptr: got %0d want 4", log_wptr_o); end
    checks++; if (log_valid_o !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wrap_valid: got %h want ffffffff", log_valid_o); end
    checks++; if (log_addr_o[31:0] !== 32'h220 || log_data_o[7:0] !== 8'h60) begin errors++; $display("[TB] FAIL wrap_slot0: got %h/%h want 220/60", log_addr_o[31:0], log_data_o[7:0]); end
    checks++; if (log_addr_o[127:96] !== 32'h223 || log_data_o[31:24] !== 8'h63) begin errors++; $display("[TB] FAIL wrap_slot3: got %h/%h want 223/63", log_addr_o[127:96], log_data_o[31:24]); end
    access(1'b0, 4'hF, 32'h200, 32'h0, w, rv, rd, er);
    checks++; if (rd !== 32'h0000_0200) begin errors++; $display("[TB] FAIL wrap_evicted: got %h want 00000200", rd); end
    access(1'b0, 4'hF, 32'h204, 32'h0, w, rv, rd, er);
    checks++; if (rd !== 32'h4746_4544) begin errors++; $display("[TB] FAIL wrap_kept: got %h want 47464544", rd); end
  endtask

  task automatic test_newest();
    int w; logic rv; logic [31:0] rd; logic er;
    access(1'b1, 4'b0001, 32'h300, 32'h11, w, rv, rd, er);
    access(1'b1, 4'b0001, 32'h300, 32'h22, w, rv, rd, er);
    access(1'b0, 4'hF, 32'h300, 32'h0, w, rv, rd, er);
    checks++; if (rd !== 32'h0000_0322) begin errors++; $display("[TB] FAIL newest_rdata: got %h want 00000322", rd); end
    access(1'b0, 4'b0010, 32'h300, 32'h0, w, rv, rd, er);
    checks++; if (rd !== 32'h0000_0300) begin errors++; $display("[TB] FAIL lane_disabled: got %h want 00000300", rd); end
    checks++; if (log_wptr_o !== 5'd6) begin errors++; $display("[TB] FAIL newest_wptr: got %0d want 6", log_wptr_o); end
  endtask

  task automatic test_error();
    int w; logic rv; logic [31:0] rd; logic er;
    access(1'b0, 4'hF, 32'hFFFF_F010, 32'h0, w, rv, rd, er);
    checks++; if (rv !== 1'b1 || er !== 1'b1) begin errors++; $display("[TB] FAIL err_load: got rv=%b err=%b want 1/1", rv, er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL err_load_rdata: got %h want 0", rd); end
    access(1'b1, 4'hF, 32'hFFFF_F010, 32'h1234_5678, w, rv, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL err_store: got err=%b rd=%h want 1/0", er, rd); end
    checks++; if (log_wptr_o !== 5'd6) begin errors++; $display("[TB] FAIL err_wptr: got %0d want 6", log_wptr_o); end
    checks++; if (log_addr_o[223:192] !== 32'h206 || log_data_o[55:48] !== 8'h46) begin errors++; $display("[TB] FAIL err_slot6: got %h/%h want 206/46", log_addr_o[223:192], log_data_o[55:48]); end
    access(1'b0, 4'hF, 32'hFFFF_EFFC, 32'h0, w, rv, rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'h0000_0FFC) begin errors++; $display("[TB] FAIL err_below: got err=%b rd=%h want 0/00000ffc", er, rd); end
    access(1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, w, rv, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL err_top: got err=%b rd=%h want 1/0", er, rd); end
  endtask

  task automatic test_back_to_back();
    int w; logic rv; logic [31:0] rd; logic er;
    access(1'b0, 4'hF, 32'h300, 32'h0, w, rv, rd, er);
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_be_i   = 4'hF;
    data_addr_i = 32'h300;
    @(negedge clk_i);
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gnt0: got %b want 1", data_gnt_o); end
    @(posedge clk_i); #1;
    checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h322) begin errors++; $display("[TB] FAIL b2b_rsp0: got rv=%b rd=%h want 1/00000322", data_rvalid_o, data_rdata_o); end
    data_be_i = 4'b0010;
    @(negedge clk_i);
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gnt1: got %b want 1", data_gnt_o); end
    @(posedge clk_i); #1;
    checks++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h300) begin errors++; $display("[TB] FAIL b2b_rsp1: got rv=%b rd=%h want 1/00000300", data_rvalid_o, data_rdata_o); end
    data_req_i = 1'b0;
    data_be_i  = 4'h0;
    @(posedge clk_i); #1;
    checks++; if (data_rvalid_o !== 1'b0 || data_rdata_o !== 32'h300) begin errors++; $display("[TB] FAIL b2b_idle: got rv=%b rd=%h want 0/00000300", data_rvalid_o, data_rdata_o); end
  endtask

  task automatic test_reset_in_miss();
    logic sawGnt;
    sawGnt      = 1'b0;
    data_req_i  = 1'b1;
    data_we_i   = 1'b0;
    data_be_i   = 4'hF;
    data_addr_i = 32'h400;
    @(negedge clk_i);
    checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL rim_gnt_early: got %b want 0", data_gnt_o); end
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    checks++; if (miss_count_o !== 32'd0) begin errors++; $display("[TB] FAIL rim_miss: got %0d want 0", miss_count_o); end
    checks++; if (log_valid_o !== 32'h0 || log_wptr_o !== 5'd0) begin errors++; $display("[TB] FAIL rim_log: got valid=%h wptr=%0d want 0/0", log_valid_o, log_wptr_o); end
    checks++; if (log_addr_o[31:0] !== 32'h0) begin errors++; $display("[TB] FAIL rim_slot0: got %h want 0", log_addr_o[31:0]); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      if (data_gnt_o !== 1'b0 || data_rvalid_o !== 1'b0) sawGnt = 1'b1;
    end
    checks++; if (sawGnt !== 1'b0) begin errors++; $display("[TB] FAIL rim_gnt: got activity=%b want 0", sawGnt); end
    rst_ni     = 1'b1;
    data_req_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_miss_load();
    test_store_hit();
    test_wrap();
    test_newest();
    test_error();
    test_back_to_back();
    test_reset_in_miss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
